// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the multi-VC NoC input-port controller:
//   - 2-bit flit type codes carried in the flit type field
//   - per-VC packet FSM state encoding
//   - flit_decode(): pulls the type and destination fields out of a flit
// No ports (package).
// -----------------------------------------------------------------------------
package noc_pkg;

   localparam logic [1:0] FLIT_HEAD     = 2'b00;
   localparam logic [1:0] FLIT_BODY     = 2'b01;
   localparam logic [1:0] FLIT_TAIL     = 2'b10;
   localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

   // Widest flit / destination the decode helper accepts; callers zero-extend.
   localparam int FLIT_MAX_W = 64;
   localparam int DEST_MAX_W = 16;

   typedef enum logic [1:0] {
      VC_IDLE    = 2'd0,
      VC_ROUTING = 2'd1,
      VC_VA      = 2'd2,
      VC_ACTIVE  = 2'd3
   } vc_state_t;

   typedef struct packed {
      logic [1:0]            ftype;
      logic [DEST_MAX_W-1:0] dest;
   } flit_info_t;

   function automatic flit_info_t flit_decode(input logic [FLIT_MAX_W-1:0] flit,
                                              input int type_lsb,
                                              input int dest_lsb,
                                              input int dest_w);
      flit_info_t info;
      logic [FLIT_MAX_W-1:0] mask;
      mask       = (FLIT_MAX_W'(1) << dest_w) - FLIT_MAX_W'(1);
      info.ftype = flit[type_lsb +: 2];
      info.dest  = DEST_MAX_W'((flit >> dest_lsb) & mask);
      return info;
   endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter
// Combinational round-robin pick: grants the lowest requester at or after the
// externally held pointer, wrapping modulo NUM_VC.
//   req  in  NUM_VC          request vector
//   ptr  in  log2(NUM_VC)    priority pointer (owned by the caller)
//   gnt  out NUM_VC          one-hot grant, all zero when no request
// -----------------------------------------------------------------------------
module noc_rr_arbiter #(
   parameter int NUM_VC = 4
) (
   input  logic [NUM_VC-1:0]         req,
   input  logic [$clog2(NUM_VC)-1:0] ptr,
   output logic [NUM_VC-1:0]         gnt
);

   localparam int VC_W = $clog2(NUM_VC);

   logic [VC_W-1:0] idx;

   // Scan from the farthest offset back towards the pointer so the closest
   // requester is the last (and therefore winning) assignment.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int i = NUM_VC - 1; i >= 0; i--) begin
         idx = ptr + VC_W'(i);
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_vc_input_ctrl.sv
// -----------------------------------------------------------------------------
// noc_vc_input_ctrl
// Multi-VC input-port controller. One packet FSM per input VC
// (IDLE -> ROUTING -> VA -> ACTIVE), a single shared route-computation unit
// handed out round-robin, per-VC stored route/output VC, and a registered
// forwarding stage driven by the switch grant.
//
// Optional build macro: NOC_PROTO_CHECK_EN
//   defined   : stray body/tail in IDLE is discarded, a second head inside a
//               packet is forwarded without ending it, both set err_flags[v]
//   undefined : no err_flags port; any valid flit in IDLE starts a packet
//
// Ports:
//   clk, rst (async, active-low)
//   buf_valid/buf_flit/buf_pop     per-VC input buffer front and dequeue
//   rc_req/rc_dest/rc_done/rc_dir  shared route computation handshake
//   va_req/va_dir/va_gnt/va_ovc    output-VC allocation
//   sa_req/sa_dir/sa_gnt           switch allocation (sa_gnt at most one hot)
//   out_valid/out_flit/out_dir/out_ovc  forwarded flit, one cycle after grant
//   err_flags (macro only)         sticky per-VC protocol error
// -----------------------------------------------------------------------------
module noc_vc_input_ctrl
   import noc_pkg::*;
#(
   parameter int FLIT_W   = 16,
   parameter int NUM_VC   = 4,
   parameter int DIR_W    = 3,
   parameter int DEST_W   = 4,
   parameter int DEST_LSB = 7,
   parameter int TYPE_LSB = 2
) (
   input  logic                       clk,
   input  logic                       rst,
`ifdef NOC_PROTO_CHECK_EN
   output logic [NUM_VC-1:0]          err_flags,
`endif
   input  logic [NUM_VC-1:0]          buf_valid,
   input  logic [NUM_VC*FLIT_W-1:0]   buf_flit,
   output logic [NUM_VC-1:0]          buf_pop,
   output logic                       rc_req,
   output logic [DEST_W-1:0]          rc_dest,
   input  logic                       rc_done,
   input  logic [DIR_W-1:0]           rc_dir,
   output logic [NUM_VC-1:0]          va_req,
   output logic [NUM_VC*DIR_W-1:0]    va_dir,
   input  logic [NUM_VC-1:0]          va_gnt,
   input  logic [$clog2(NUM_VC)-1:0]  va_ovc,
   output logic [NUM_VC-1:0]          sa_req,
   output logic [NUM_VC*DIR_W-1:0]    sa_dir,
   input  logic [NUM_VC-1:0]          sa_gnt,
   output logic                       out_valid,
   output logic [FLIT_W-1:0]          out_flit,
   output logic [DIR_W-1:0]           out_dir,
   output logic [$clog2(NUM_VC)-1:0]  out_ovc
);

   localparam int VC_W = $clog2(NUM_VC);

   logic [NUM_VC-1:0]        routing_vec;
   logic [NUM_VC-1:0]        sa_fire;
   logic [NUM_VC-1:0]        arb_gnt;
   logic [VC_W-1:0]          arb_idx;
   logic [NUM_VC*DEST_W-1:0] dest_flat;
   logic [NUM_VC*DIR_W-1:0]  dir_flat;
   logic [NUM_VC*VC_W-1:0]   ovc_flat;

   logic                     owner_valid_reg;
   logic [VC_W-1:0]          owner_reg;
   logic [VC_W-1:0]          rr_ptr_reg;
   logic                     rc_fire;

   logic                     out_valid_reg;
   logic [FLIT_W-1:0]        out_flit_reg;
   logic [DIR_W-1:0]         out_dir_reg;
   logic [VC_W-1:0]          out_ovc_reg;

   // rc_done only counts while someone actually owns the RC unit.
   assign rc_fire = rc_done && owner_valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
         vc_state_t        state_reg;
         logic [DIR_W-1:0] dir_reg;
         logic [VC_W-1:0]  ovc_reg;
         logic [FLIT_W-1:0] flit;
         flit_info_t       info;
         logic             is_tail;
         logic             rc_hit;

         assign flit    = buf_flit[gi*FLIT_W +: FLIT_W];
         assign info    = flit_decode(FLIT_MAX_W'(flit), TYPE_LSB, DEST_LSB, DEST_W);
         assign is_tail = (info.ftype == FLIT_TAIL) || (info.ftype == FLIT_HEADTAIL);
         assign rc_hit  = rc_fire && (owner_reg == VC_W'(gi));

         assign routing_vec[gi] = (state_reg == VC_ROUTING);
         assign va_req[gi]      = (state_reg == VC_VA);
         assign sa_req[gi]      = (state_reg == VC_ACTIVE) && buf_valid[gi];
         assign sa_fire[gi]     = sa_req[gi] && sa_gnt[gi];

         assign va_dir[gi*DIR_W +: DIR_W]     = dir_reg;
         assign sa_dir[gi*DIR_W +: DIR_W]     = dir_reg;
         assign dir_flat[gi*DIR_W +: DIR_W]   = dir_reg;
         assign ovc_flat[gi*VC_W +: VC_W]     = ovc_reg;
         assign dest_flat[gi*DEST_W +: DEST_W] = info.dest[DEST_W-1:0];

`ifdef NOC_PROTO_CHECK_EN
         logic is_head;
         logic drop;
         logic err_reg;
         // head_seen_reg marks that this packet's own head already crossed the
         // switch, so any later head in the same packet is a protocol error.
         logic head_seen_reg;

         assign is_head = (info.ftype == FLIT_HEAD) || (info.ftype == FLIT_HEADTAIL);
         // Gated with rst so the discard pulse also obeys "outputs 0 in reset".
         assign drop        = rst && (state_reg == VC_IDLE) && buf_valid[gi] && !is_head;
         assign buf_pop[gi] = sa_fire[gi] | drop;
         assign err_flags[gi] = err_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_reg     <= VC_IDLE;
               dir_reg       <= '0;
               ovc_reg       <= '0;
               err_reg       <= 1'b0;
               head_seen_reg <= 1'b0;
            end else begin
               case (state_reg)
                  VC_IDLE: begin
                     if (buf_valid[gi]) begin
                        if (is_head) state_reg <= VC_ROUTING;
                        else         err_reg   <= 1'b1;
                     end
                  end
                  VC_ROUTING: begin
                     if (rc_hit) begin
                        dir_reg   <= rc_dir;
                        state_reg <= VC_VA;
                     end
                  end
                  VC_VA: begin
                     if (va_gnt[gi]) begin
                        ovc_reg       <= va_ovc;
                        head_seen_reg <= 1'b0;
                        state_reg     <= VC_ACTIVE;
                     end
                  end
                  default: begin
                     if (sa_fire[gi]) begin
                        head_seen_reg <= 1'b1;
                        if (head_seen_reg && is_head) err_reg   <= 1'b1;
                        else if (is_tail)             state_reg <= VC_IDLE;
                     end
                  end
               endcase
            end
         end
`else
         assign buf_pop[gi] = sa_fire[gi];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_reg <= VC_IDLE;
               dir_reg   <= '0;
               ovc_reg   <= '0;
            end else begin
               case (state_reg)
                  VC_IDLE: begin
                     if (buf_valid[gi]) state_reg <= VC_ROUTING;
                  end
                  VC_ROUTING: begin
                     if (rc_hit) begin
                        dir_reg   <= rc_dir;
                        state_reg <= VC_VA;
                     end
                  end
                  VC_VA: begin
                     if (va_gnt[gi]) begin
                        ovc_reg   <= va_ovc;
                        state_reg <= VC_ACTIVE;
                     end
                  end
                  default: begin
                     // A head here is simply forwarded like a body.
                     if (sa_fire[gi] && is_tail) state_reg <= VC_IDLE;
                  end
               endcase
            end
         end
`endif
      end
   endgenerate

   noc_rr_arbiter #(
      .NUM_VC (NUM_VC)
   ) u_rc_arb (
      .req (routing_vec),
      .ptr (rr_ptr_reg),
      .gnt (arb_gnt)
   );

   always_comb begin
      arb_idx = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (arb_gnt[v]) arb_idx = VC_W'(v);
      end
   end

   // RC ownership: arbitrate only while unowned, so a VC entering ROUTING in
   // the same cycle as rc_done is considered one cycle later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_valid_reg <= 1'b0;
         owner_reg       <= '0;
         rr_ptr_reg      <= '0;
      end else if (owner_valid_reg) begin
         if (rc_done) begin
            owner_valid_reg <= 1'b0;
            rr_ptr_reg      <= owner_reg + 1'b1;
         end
      end else if (|arb_gnt) begin
         owner_valid_reg <= 1'b1;
         owner_reg       <= arb_idx;
      end
   end

   assign rc_req  = owner_valid_reg;
   assign rc_dest = owner_valid_reg ? dest_flat[owner_reg*DEST_W +: DEST_W] : '0;

   // Forwarding stage; payload holds its last value while out_valid is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_reg <= 1'b0;
         out_flit_reg  <= '0;
         out_dir_reg   <= '0;
         out_ovc_reg   <= '0;
      end else begin
         out_valid_reg <= |sa_fire;
         for (int v = 0; v < NUM_VC; v++) begin
            if (sa_fire[v]) begin
               out_flit_reg <= buf_flit[v*FLIT_W +: FLIT_W];
               out_dir_reg  <= dir_flat[v*DIR_W +: DIR_W];
               out_ovc_reg  <= ovc_flat[v*VC_W +: VC_W];
            end
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_flit  = out_flit_reg;
   assign out_dir   = out_dir_reg;
   assign out_ovc   = out_ovc_reg;

endmodule
